tx_mailbox_controller: RTL and testbench
========================================

# tx_mailbox_controller

Transmit-side mailbox for the processor's message interface: the processor core loads an outgoing word into a per-channel slot and marks it pending. The block then drains pending slots onto the link serializer through a valid/ready handshake and clears each slot's pending flag when the link accepts the word. It is the sending-end counterpart of the receive flags register file, which sets a flag on arrival and clears it on read. The core polls `read_data` to learn whether a channel's slot is still busy.

## Interface
Parameters:
- `ADDR_WIDTH_RF`, default 1: channel address width; `2**ADDR_WIDTH_RF` channels.
- `DATA_WIDTH`, default 32: message word width.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `tx_write_enable`  in  1: core request to load `write_data` into slot `address_1`.
- `address_1`  in  `ADDR_WIDTH_RF`: channel to load.
- `write_data`  in  `DATA_WIDTH`: outgoing word.
- `address_2`  in  `ADDR_WIDTH_RF`: channel to poll.
- `read_data`  out  1: pending flag of channel `address_2` (combinational).
- `tx_write_error`  out  1: registered one-cycle pulse; load rejected because the slot was busy.
- `link_valid`  out  1: word presented to the serializer.
- `link_ready`  in  1: serializer accepts the word.
- `link_channel`  out  `ADDR_WIDTH_RF`: channel of the presented word.
- `link_data`  out  `DATA_WIDTH`: presented word.

## Operation
- State per channel: `pending[c]` (1 bit) and `slot_data[c]` (`DATA_WIDTH`).
- Load: when `tx_write_enable` is 1 and `pending[address_1]` is 0, the block writes `slot_data[address_1]` and sets `pending[address_1]`. When `pending[address_1]` is 1, the load is dropped, slot contents are unchanged, and `tx_write_error` is 1 for the next cycle.
- Busy sampling: a load's busy check uses `pending` as it stood before the edge.
  - A load to the channel being cleared by a handshake on the same edge is rejected.
- Arbitration: round-robin over pending channels, starting from the channel after `last_served`.
- FSM states:
  - `IDLE`: `link_valid`=0. If any channel is pending, latch the arbiter winner into `link_channel`/`link_data` and go to `SEND`; otherwise stay.
  - `SEND`: `link_valid`=1. `link_channel` and `link_data` are held stable.
    - On `link_valid & link_ready`: clear `pending[link_channel]`, set `last_served`=`link_channel`, go to `IDLE`.
    - Otherwise stay in `SEND`; there is no timeout and no retraction.
- `read_data` = `pending[address_2]` with no added latency.
  - A channel reads busy from the edge after its load until the edge of its handshake.

## Timing
- Reset values, applied asynchronously on `reset_n`=0:
  - `pending` all 0 and `slot_data` all 0.
  - State `IDLE` and `last_served` = `2**ADDR_WIDTH_RF-1`, so channel 0 wins first.
  - `link_valid`=0, `link_channel`=0, `link_data`=0, `tx_write_error`=0.
- Load accepted at edge E0:
  - `pending`=1 after E0.
  - FSM enters `SEND` at E1, so `link_valid`=1 after E1.
  - The earliest handshake is E2, with `pending` cleared after E2.
- Per-word throughput: 2 cycles minimum (`SEND` → `IDLE` → `SEND`).
- `link_ready` may be held high permanently; the transfer completes on the first `SEND` edge.
- Reset asserted mid-`SEND`: the word is discarded, `link_valid` drops asynchronously, and every pending slot is lost.
- All channels pending: each channel is served exactly once per `2**ADDR_WIDTH_RF` transfers.

## Structure
- Package `tx_mailbox_pkg`:
  - `tx_state_t` enum {`IDLE`, `SEND`}.
  - `NUM_CHANNELS` derivation helper.
  - Default `DATA_WIDTH` constant, shared with the receive side.
- Sub-module `round_robin_arbiter`:
  - Parameter `N`.
  - Inputs: `request[N]`, `last_served`.
  - Outputs: `grant_index`, `grant_valid`.
  - Purely combinational.

## Test plan
- Reset, then load ch0=0xDEADBEEF with `link_ready`=1:
  - `read_data`(ch0)=1 from E0.
  - `link_valid`=1 with `link_channel`=0 and `link_data`=0xDEADBEEF during E1–E2.
  - `read_data`(ch0)=0 after E2.
- Load ch1 with `link_ready`=0 for 5 cycles, then load ch1 again:
  - `link_valid`, `link_channel` and `link_data` stay stable throughout.
  - The second load raises `tx_write_error` for 1 cycle and `slot_data` is unchanged.
- Load ch0 and ch1 in consecutive cycles with `link_ready`=1:
  - Transfer order is ch0 then ch1.
  - Next round with both pending after `last_served`=1: ch0 first.
- Load the active channel on the same edge as its handshake:
  - The load is rejected and `tx_write_error`=1.
  - `pending` ends at 0.
- Assert `reset_n`=0 mid-`SEND` with `link_ready`=0:
  - `link_valid`=0 immediately.
  - All `read_data`=0, and no transfer occurs after release.
- `ADDR_WIDTH_RF`=2 with all 4 channels loaded and `link_ready`=1:
  - Grants run 0,1,2,3.
  - Exactly 8 cycles from first `SEND` entry to final clear.

Source files
------------

// File: rtl/tx_mailbox_controller_pkg.sv
// ---------------------------------------------------------------------------
// tx_mailbox_pkg
// Shared types and constants for the transmit mailbox and its link interface.
//   tx_state_t         : drain FSM state (IDLE waits for work, SEND holds a word)
//   num_channels()     : channel count derived from the channel address width
//   DEFAULT_DATA_WIDTH : message word width, shared with the receive side
// ---------------------------------------------------------------------------
package tx_mailbox_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;

  function automatic int num_channels(input int addr_width);
    return 32'sd1 <<< addr_width;
  endfunction

endpackage

// File: rtl/tx_mailbox_controller_if.sv
// ---------------------------------------------------------------------------
// tx_mailbox_link_if
// Valid/ready link between the transmit mailbox and the link serializer.
//   link_valid   : word presented (mailbox -> serializer)
//   link_ready   : serializer accepts the word (serializer -> mailbox)
//   link_channel : channel of the presented word
//   link_data    : presented word
// Modports: master = mailbox side, slave = serializer side.
// ---------------------------------------------------------------------------
interface tx_mailbox_link_if #(
  parameter int ADDR_WIDTH_RF = 1,
  parameter int DATA_WIDTH    = tx_mailbox_pkg::DEFAULT_DATA_WIDTH
);

  logic                     link_valid;
  logic                     link_ready;
  logic [ADDR_WIDTH_RF-1:0] link_channel;
  logic [DATA_WIDTH-1:0]    link_data;

  modport master (
    output link_valid,
    output link_channel,
    output link_data,
    input  link_ready
  );

  modport slave (
    input  link_valid,
    input  link_channel,
    input  link_data,
    output link_ready
  );

endinterface

// File: rtl/tx_mailbox_controller_arbiter.sv
// ---------------------------------------------------------------------------
// round_robin_arbiter
// Purely combinational round-robin pick over N request lines. The search
// starts at the index just after last_served and wraps, so the most recently
// served channel has the lowest priority.
//   request     : one bit per channel
//   last_served : index granted by the previous completed transfer
//   grant_index : winning channel (0 when nothing is requested)
//   grant_valid : at least one request is present
// ---------------------------------------------------------------------------
module round_robin_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         request,
  input  logic [$clog2(N)-1:0] last_served,
  output logic [$clog2(N)-1:0] grant_index,
  output logic                 grant_valid
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand_s;

  // Walk offsets from farthest to nearest so the nearest requester after
  // last_served is the last (and therefore winning) assignment.
  always_comb begin
    grant_index = {IW{1'b0}};
    grant_valid = 1'b0;
    cand_s      = {IW{1'b0}};
    for (int off = N; off >= 1; off--) begin
      cand_s = IW'((int'(last_served) + off) % N);
      if (request[cand_s]) begin
        grant_index = cand_s;
        grant_valid = 1'b1;
      end else begin
        grant_index = grant_index;
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/tx_mailbox_controller.sv
// ---------------------------------------------------------------------------
// tx_mailbox_controller
// Transmit mailbox: the core loads outgoing words into per-channel slots and
// marks them pending; a two-state FSM drains pending slots round-robin onto
// the link and clears each pending flag when the link accepts the word.
//   clk, reset_n      : clock, asynchronous active-low reset
//   tx_write_enable   : load write_data into slot address_1
//   address_1         : channel to load
//   write_data        : outgoing word
//   address_2         : channel to poll
//   read_data         : pending flag of address_2 (combinational)
//   tx_write_error    : one-cycle pulse, load rejected because slot was busy
//   link (master)     : valid/ready word output to the serializer
// ---------------------------------------------------------------------------
module tx_mailbox_controller
  import tx_mailbox_pkg::*;
#(
  parameter int ADDR_WIDTH_RF = 1,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tx_write_enable,
  input  logic [ADDR_WIDTH_RF-1:0] address_1,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic [ADDR_WIDTH_RF-1:0] address_2,
  output logic                     read_data,
  output logic                     tx_write_error,
  tx_mailbox_link_if.master        link
);

  localparam int NUM_CH = num_channels(ADDR_WIDTH_RF);

  logic [NUM_CH-1:0]        pending_r;
  logic [DATA_WIDTH-1:0]    slot_data_r [NUM_CH];
  tx_state_t                state_r;
  logic [ADDR_WIDTH_RF-1:0] last_served_r;
  logic                     link_valid_r;
  logic [ADDR_WIDTH_RF-1:0] link_channel_r;
  logic [DATA_WIDTH-1:0]    link_data_r;
  logic                     tx_write_error_r;

  logic                     load_busy_s;
  logic                     load_accept_s;
  logic                     handshake_s;
  logic [ADDR_WIDTH_RF-1:0] grant_index_s;
  logic                     grant_valid_s;

  round_robin_arbiter #(
    .N (NUM_CH)
  ) u_arbiter (
    .request     (pending_r),
    .last_served (last_served_r),
    .grant_index (grant_index_s),
    .grant_valid (grant_valid_s)
  );

  // Load and handshake qualifiers; the busy check sees pending before the edge,
  // so a load aimed at the channel being handed off this edge is rejected.
  always_comb begin
    load_busy_s   = pending_r[address_1];
    load_accept_s = tx_write_enable & ~load_busy_s;
    handshake_s   = (state_r == SEND) & link_valid_r & link.link_ready;
  end

  assign read_data         = pending_r[address_2];
  assign tx_write_error    = tx_write_error_r;
  assign link.link_valid   = link_valid_r;
  assign link.link_channel = link_channel_r;
  assign link.link_data    = link_data_r;

  // Slot storage, pending flags and the reject pulse. A handshake channel is
  // always pending, so an accepted load never targets it on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r        <= {NUM_CH{1'b0}};
      slot_data_r      <= '{default: {DATA_WIDTH{1'b0}}};
      tx_write_error_r <= 1'b0;
    end else begin
      tx_write_error_r <= tx_write_enable & load_busy_s;
      if (handshake_s) begin
        pending_r[link_channel_r] <= 1'b0;
      end
      if (load_accept_s) begin
        pending_r[address_1]   <= 1'b1;
        slot_data_r[address_1] <= write_data;
      end
    end
  end

  // Drain FSM: IDLE latches the arbiter winner, SEND holds it until accepted.
  // last_served resets to the top channel so channel 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      last_served_r  <= {ADDR_WIDTH_RF{1'b1}};
      link_valid_r   <= 1'b0;
      link_channel_r <= {ADDR_WIDTH_RF{1'b0}};
      link_data_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            link_channel_r <= grant_index_s;
            link_data_r    <= slot_data_r[grant_index_s];
            link_valid_r   <= 1'b1;
            state_r        <= SEND;
          end else begin
            link_valid_r   <= 1'b0;
            state_r        <= IDLE;
          end
        end
        SEND: begin
          if (handshake_s) begin
            last_served_r <= link_channel_r;
            link_valid_r  <= 1'b0;
            state_r       <= IDLE;
          end else begin
            link_valid_r  <= 1'b1;
            state_r       <= SEND;
          end
        end
        default: begin
          link_valid_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_mailbox_controller.sv
// ---------------------------------------------------------------------------
// tb_tx_mailbox_controller
// Directed bench: a 2-channel instance covers load, stall, reject, ordering,
// same-edge handoff and reset; a 4-channel instance covers round-robin order
// and drain timing with link_ready held high.
// ---------------------------------------------------------------------------
module tb_tx_mailbox_controller;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        we1;
  logic [0:0]  a1_1;
  logic [31:0] wd1;
  logic [0:0]  a2_1;
  logic        rd1;
  logic        err1;

  logic        we4;
  logic [1:0]  a1_4;
  logic [31:0] wd4;
  logic [1:0]  a2_4;
  logic        rd4;
  logic        err4;

  int total = 0;
  int bad   = 0;

  tx_mailbox_link_if #(.ADDR_WIDTH_RF(1), .DATA_WIDTH(32)) link1 ();
  tx_mailbox_link_if #(.ADDR_WIDTH_RF(2), .DATA_WIDTH(32)) link4 ();

  tx_mailbox_controller #(.ADDR_WIDTH_RF(1), .DATA_WIDTH(32)) u_dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .tx_write_enable (we1),
    .address_1       (a1_1),
    .write_data      (wd1),
    .address_2       (a2_1),
    .read_data       (rd1),
    .tx_write_error  (err1),
    .link            (link1)
  );

  tx_mailbox_controller #(.ADDR_WIDTH_RF(2), .DATA_WIDTH(32)) u_dut4 (
    .clk             (clk),
    .reset_n         (reset_n),
    .tx_write_enable (we4),
    .address_1       (a1_4),
    .write_data      (wd4),
    .address_2       (a2_4),
    .read_data       (rd4),
    .tx_write_error  (err4),
    .link            (link4)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0;
    we1 = 1'b0; a1_1 = 1'b0; wd1 = 32'h0; a2_1 = 1'b0; link1.link_ready = 1'b0;
    we4 = 1'b0; a1_4 = 2'd0; wd4 = 32'h0; a2_4 = 2'd0; link4.link_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (link1.link_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", link1.link_valid); end
    total++; if (link1.link_channel !== 1'b0) begin bad++; $display("FAIL reset_channel: got %h expected 0", link1.link_channel); end
    total++; if (link1.link_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h expected 0", link1.link_data); end
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL reset_error: got %b expected 0", err1); end
    a2_1 = 1'b1; #1;
    total++; if (rd1 !== 1'b0) begin bad++; $display("FAIL reset_read_ch1: got %b expected 0", rd1); end
    a2_1 = 1'b0; #1;
    total++; if (rd1 !== 1'b0) begin bad++; $display("FAIL reset_read_ch0: got %b expected 0", rd1); end
    total++; if (link4.link_valid !== 1'b0) begin bad++; $display("FAIL reset_valid4: got %b expected 0", link4.link_valid); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic_load();
    @(negedge clk);
    link1.link_ready = 1'b1; we1 = 1'b1; a1_1 = 1'b0; wd1 = 32'hDEADBEEF; a2_1 = 1'b0;
    @(negedge clk);
    we1 = 1'b0;
    total++; if (rd1 !== 1'b1) begin bad++; $display("FAIL basic_busy_after_load: got %b expected 1", rd1); end
    total++; if (link1.link_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_e0: got %b expected 0", link1.link_valid); end
    @(negedge clk);
    total++; if (link1.link_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_e1: got %b expected 1", link1.link_valid); end
    total++; if (link1.link_channel !== 1'b0) begin bad++; $display("FAIL basic_channel: got %h expected 0", link1.link_channel); end
    total++; if (link1.link_data !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_data: got %h expected deadbeef", link1.link_data); end
    total++; if (rd1 !== 1'b1) begin bad++; $display("FAIL basic_busy_send: got %b expected 1", rd1); end
    @(negedge clk);
    total++; if (link1.link_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_e2: got %b expected 0", link1.link_valid); end
    total++; if (rd1 !== 1'b0) begin bad++; $display("FAIL basic_cleared: got %b expected 0", rd1); end
  endtask

  task automatic test_stall_and_reject();
    @(negedge clk);
    link1.link_ready = 1'b0; we1 = 1'b1; a1_1 = 1'b1; wd1 = 32'h12345678; a2_1 = 1'b1;
    @(negedge clk);
    we1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (link1.link_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, link1.link_valid); end
      total++; if (link1.link_channel !== 1'b1) begin bad++; $display("FAIL stall_channel[%0d]: got %h expected 1", i, link1.link_channel); end
      total++; if (link1.link_data !== 32'h12345678) begin bad++; $display("FAIL stall_data[%0d]: got %h expected 12345678", i, link1.link_data); end
      if (i == 2) begin
        total++; if (err1 !== 1'b1) begin bad++; $display("FAIL stall_ch0_reject_err: got %b expected 1", err1); end
      end
      if (i == 3) begin
        total++; if (err1 !== 1'b0) begin bad++; $display("FAIL stall_ch0_err_pulse: got %b expected 0", err1); end
      end
      we1  = (i < 2);
      a1_1 = 1'b0;
      wd1  = (i == 0) ? 32'hA5A50001 : 32'h0BAD0BAD;
    end
    @(negedge clk);
    we1 = 1'b1; a1_1 = 1'b1; wd1 = 32'hFFFF0000;
    @(negedge clk);
    we1 = 1'b0;
    total++; if (err1 !== 1'b1) begin bad++; $display("FAIL reload_err: got %b expected 1", err1); end
    total++; if (link1.link_data !== 32'h12345678) begin bad++; $display("FAIL reload_data_held: got %h expected 12345678", link1.link_data); end
    total++; if (rd1 !== 1'b1) begin bad++; $display("FAIL reload_still_busy: got %b expected 1", rd1); end
    @(negedge clk);
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL reload_err_pulse: got %b expected 0", err1); end
    link1.link_ready = 1'b1;
    @(negedge clk);
    total++; if (link1.link_valid !== 1'b0) begin bad++; $display("FAIL stall_release_valid: got %b expected 0", link1.link_valid); end
    total++; if (rd1 !== 1'b0) begin bad++; $display("FAIL stall_release_clear: got %b expected 0", rd1); end
    @(negedge clk);
    total++; if (link1.link_channel !== 1'b0) begin bad++; $display("FAIL slot0_channel: got %h expected 0", link1.link_channel); end
    total++; if (link1.link_data !== 32'hA5A50001) begin bad++; $display("FAIL slot0_unchanged: got %h expected a5a50001", link1.link_data); end
    @(negedge clk);
    a2_1 = 1'b0; #1;
    total++; if (rd1 !== 1'b0) begin bad++; $display("FAIL slot0_cleared: got %b expected 0", rd1); end
  endtask

  task automatic test_order();
    link1.link_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      we1 = 1'b1; a1_1 = 1'b0; wd1 = 32'h00000A0A + 32'(r);
      @(negedge clk);
      we1 = 1'b1; a1_1 = 1'b1; wd1 = 32'h00000B0B + 32'(r);
      @(negedge clk);
      we1 = 1'b0;
      total++; if (link1.link_channel !== 1'b0 || link1.link_valid !== 1'b1) begin bad++; $display("FAIL order_first[%0d]: got v=%b ch=%h expected v=1 ch=0", r, link1.link_valid, link1.link_channel); end
      total++; if (link1.link_data !== 32'h00000A0A + 32'(r)) begin bad++; $display("FAIL order_first_data[%0d]: got %h expected %h", r, link1.link_data, 32'h00000A0A + 32'(r)); end
      @(negedge clk);
      @(negedge clk);
      total++; if (link1.link_channel !== 1'b1 || link1.link_valid !== 1'b1) begin bad++; $display("FAIL order_second[%0d]: got v=%b ch=%h expected v=1 ch=1", r, link1.link_valid, link1.link_channel); end
      total++; if (link1.link_data !== 32'h00000B0B + 32'(r)) begin bad++; $display("FAIL order_second_data[%0d]: got %h expected %h", r, link1.link_data, 32'h00000B0B + 32'(r)); end
      @(negedge clk);
      total++; if (link1.link_valid !== 1'b0) begin bad++; $display("FAIL order_done[%0d]: got %b expected 0", r, link1.link_valid); end
    end
  endtask

  task automatic test_same_edge_load();
    @(negedge clk);
    link1.link_ready = 1'b0; we1 = 1'b1; a1_1 = 1'b0; wd1 = 32'h5555AAAA; a2_1 = 1'b0;
    @(negedge clk);
    we1 = 1'b0;
    @(negedge clk);
    total++; if (link1.link_valid !== 1'b1) begin bad++; $display("FAIL same_edge_send: got %b expected 1", link1.link_valid); end
    link1.link_ready = 1'b1; we1 = 1'b1; a1_1 = 1'b0; wd1 = 32'h77777777;
    @(negedge clk);
    we1 = 1'b0;
    total++; if (err1 !== 1'b1) begin bad++; $display("FAIL same_edge_err: got %b expected 1", err1); end
    total++; if (rd1 !== 1'b0) begin bad++; $display("FAIL same_edge_pending: got %b expected 0", rd1); end
    @(negedge clk);
    total++; if (link1.link_valid !== 1'b0) begin bad++; $display("FAIL same_edge_no_resend: got %b expected 0", link1.link_valid); end
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL same_edge_err_pulse: got %b expected 0", err1); end
  endtask

  task automatic test_reset_mid_send();
    @(negedge clk);
    link1.link_ready = 1'b0; we1 = 1'b1; a1_1 = 1'b0; wd1 = 32'h11111111;
    @(negedge clk);
    a1_1 = 1'b1; wd1 = 32'h22222222;
    @(negedge clk);
    we1 = 1'b0;
    @(negedge clk);
    total++; if (link1.link_valid !== 1'b1) begin bad++; $display("FAIL midreset_send: got %b expected 1", link1.link_valid); end
    reset_n = 1'b0;
    #1;
    total++; if (link1.link_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid_async: got %b expected 0", link1.link_valid); end
    a2_1 = 1'b0; #1;
    total++; if (rd1 !== 1'b0) begin bad++; $display("FAIL midreset_read_ch0: got %b expected 0", rd1); end
    a2_1 = 1'b1; #1;
    total++; if (rd1 !== 1'b0) begin bad++; $display("FAIL midreset_read_ch1: got %b expected 0", rd1); end
    @(negedge clk);
    reset_n = 1'b1; link1.link_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (link1.link_valid !== 1'b0) begin bad++; $display("FAIL midreset_no_transfer[%0d]: got %b expected 0", i, link1.link_valid); end
    end
  endtask

  task automatic test_four_channel();
    int  order [4];
    logic [31:0] data [4];
    int  n       = 0;
    int  cnt     = 0;
    bit  started = 1'b0;
    bit  done    = 1'b0;
    logic any_p;
    for (int j = 0; j < 4; j++) begin order[j] = -1; data[j] = 32'h0; end
    link4.link_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (link4.link_valid === 1'b1 && n < 4) begin
        order[n] = int'(link4.link_channel);
        data[n]  = link4.link_data;
        n++;
      end
      if (!started && link4.link_valid === 1'b1) begin
        started = 1'b1;
        cnt     = 1;
      end else if (started) begin
        cnt++;
      end
      any_p = 1'b0;
      for (int c = 0; c < 4; c++) begin
        a2_4 = 2'(c); #1;
        any_p = any_p | rd4;
      end
      if (started && !any_p) begin
        done = 1'b1;
        we4  = 1'b0;
        break;
      end
      if (k < 4) begin
        we4 = 1'b1; a1_4 = 2'(k); wd4 = 32'h10000000 + 32'(k);
      end else begin
        we4 = 1'b0;
      end
    end
    total++; if (!done) begin bad++; $display("FAIL four_drain_timeout: got done=%b expected 1", done); end
    total++; if (n !== 4) begin bad++; $display("FAIL four_transfer_count: got %0d expected 4", n); end
    total++; if (cnt !== 8) begin bad++; $display("FAIL four_drain_cycles: got %0d expected 8", cnt); end
    for (int j = 0; j < 4; j++) begin
      total++; if (order[j] !== j) begin bad++; $display("FAIL four_grant[%0d]: got %0d expected %0d", j, order[j], j); end
      total++; if (data[j] !== 32'h10000000 + 32'(j)) begin bad++; $display("FAIL four_data[%0d]: got %h expected %h", j, data[j], 32'h10000000 + 32'(j)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_stall_and_reject();
    test_order();
    test_same_edge_load();
    test_reset_mid_send();
    test_four_channel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
